// File: rtl/ctrl_pkg.sv
// Shared definitions for the branch controller: default widths and jump-source encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

    // Default PC/target width, jump-table index width and return-stack depth.
    localparam int DEFAULT_D     = 10;
    localparam int DEFAULT_LUT_W = 5;
    localparam int DEFAULT_DEPTH = 8;

    // Winning request after priority decode (ret > call > br).
    typedef enum logic [1:0] {
        JS_NONE = 2'd0,
        JS_BR   = 2'd1,
        JS_CALL = 2'd2,
        JS_RET  = 2'd3
    } jump_src_t;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack: push/pop with full/empty and overflow/underflow pulses.
// Latency: top_o/full_o/empty_o reflect registered state; push/pop take effect on the next clk edge.
// Backpressure: none; a push when full or a pop when empty is dropped and flagged on ovf_o/unf_o.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the stack)
//   push_i/push_dat_i push request and the address to store
//   pop_i             pop request (has precedence if asserted together with push_i)
//   top_o             entry at sp-1 (meaningless while empty_o = 1)
//   full_o/empty_o    sp == DEPTH / sp == 0
//   ovf_o/unf_o       combinational pulses: push while full / pop while empty
module ret_stack #(
    parameter int D     = 10,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [D-1:0] push_dat_i,
    output logic [D-1:0] top_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         ovf_o,
    output logic         unf_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [D-1:0]   mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign full_o  = (sp_q == SPW'(DEPTH));
    assign empty_o = (sp_q == '0);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~pop_i & ~full_o;
    assign ovf_o   = push_i & ~pop_i & full_o;
    assign unf_o   = pop_i & empty_o;

    // DEPTH is a power of two, so when sp == DEPTH the low bits are 0 and
    // subtracting one wraps to DEPTH-1, which is exactly the top entry.
    assign top_o = mem_q[sp_q[AW-1:0] - AW'(1)];

    always_comb begin
        sp_d = sp_q;
        if (do_pop) begin
            sp_d = sp_q - SPW'(1);
        end else if (do_push) begin
            sp_d = sp_q + SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Contents need no reset: resetting sp makes every entry unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[sp_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/call/return controller producing the PC's absolute-jump controls.
// Latency: absjump_en/target are combinational in the request cycle; LUT/stack update on that edge.
// Backpressure: none; requests are accepted every cycle, a blocked call/ret sets sticky stack_err.
//
// Optional feature: define BRANCH_CTRL_TAKEN_CNT_EN to add a 16-bit taken-jump counter (taken_cnt).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   prog_ctr                   current PC (call pushes prog_ctr + 1)
//   br_en, cond_flag           conditional branch request and its condition
//   call_en, ret_en            call / return requests (priority ret > call > br)
//   lut_idx                    jump-table read index for branch/call
//   lut_wr_en/_idx/_data       jump-table write port (write-after-read)
//   absjump_en, target         jump strobe and destination to the PC
//   stack_full/empty/err       return-stack status; err is sticky until reset
//   taken_cnt                  (optional) count of cycles with absjump_en = 1
module branch_ctrl
    import ctrl_pkg::*;
#(
    parameter int D     = DEFAULT_D,
    parameter int LUT_W = DEFAULT_LUT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [D-1:0]     prog_ctr,
    input  logic             br_en,
    input  logic             cond_flag,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [LUT_W-1:0] lut_idx,
    input  logic             lut_wr_en,
    input  logic [LUT_W-1:0] lut_wr_idx,
    input  logic [D-1:0]     lut_wr_data,
    output logic             absjump_en,
    output logic [D-1:0]     target,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
`ifdef BRANCH_CTRL_TAKEN_CNT_EN
    ,
    output logic [15:0]      taken_cnt
`endif
);

    localparam int LUT_N = 2 ** LUT_W;

    logic [D-1:0] lut_q [LUT_N];
    logic [D-1:0] lut_rd;
    logic [D-1:0] stk_top;
    logic         stk_push;
    logic         stk_pop;
    logic         stk_ovf;
    logic         stk_unf;
    logic         stack_err_q;
    logic         stack_err_d;
    jump_src_t    src;

    // Combinational read of the registered table gives write-after-read
    // semantics for a same-index write in the same cycle.
    assign lut_rd = lut_q[lut_idx];

    always_comb begin
        src = JS_NONE;
        if (ret_en) begin
            src = JS_RET;
        end else if (call_en) begin
            src = JS_CALL;
        end else if (br_en) begin
            src = JS_BR;
        end
    end

    // Requests are ignored entirely while reset is high, so no stack
    // activity and no jump leaks out during reset.
    always_comb begin
        absjump_en = 1'b0;
        target     = '0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        if (!reset) begin
            case (src)
                JS_RET: begin
                    stk_pop = 1'b1;
                    if (!stack_empty) begin
                        absjump_en = 1'b1;
                        target     = stk_top;
                    end
                end
                JS_CALL: begin
                    stk_push = 1'b1;
                    if (!stack_full) begin
                        absjump_en = 1'b1;
                        target     = lut_rd;
                    end
                end
                JS_BR: begin
                    if (cond_flag) begin
                        absjump_en = 1'b1;
                        target     = lut_rd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    ret_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk        (clk),
        .reset      (reset),
        .push_i     (stk_push),
        .pop_i      (stk_pop),
        .push_dat_i (prog_ctr + D'(1)),
        .top_o      (stk_top),
        .full_o     (stack_full),
        .empty_o    (stack_empty),
        .ovf_o      (stk_ovf),
        .unf_o      (stk_unf)
    );

    assign stack_err_d = stack_err_q | stk_ovf | stk_unf;
    assign stack_err   = stack_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= stack_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_wr_en) begin
            lut_q[lut_wr_idx] <= lut_wr_data;
        end
    end

`ifdef BRANCH_CTRL_TAKEN_CNT_EN
    logic [15:0] taken_cnt_q;

    // absjump_en is already forced low during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= '0;
        end else if (absjump_en) begin
            taken_cnt_q <= taken_cnt_q + 16'd1;
        end
    end

    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] prog_ctr;
    logic       br_en, cond_flag, call_en, ret_en;
    logic [4:0] lut_idx;
    logic       lut_wr_en;
    logic [4:0] lut_wr_idx;
    logic [9:0] lut_wr_data;
    logic       absjump_en;
    logic [9:0] target;
    logic       stack_full, stack_empty, stack_err;
`ifdef BRANCH_CTRL_TAKEN_CNT_EN
    logic [15:0] taken_cnt;
`endif

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .prog_ctr    (prog_ctr),
        .br_en       (br_en),
        .cond_flag   (cond_flag),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .lut_idx     (lut_idx),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
        .absjump_en  (absjump_en),
        .target      (target),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
`ifdef BRANCH_CTRL_TAKEN_CNT_EN
        ,
        .taken_cnt   (taken_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Behavioural reference: table as an array, stack as a queue.
    logic [9:0]  m_lut [32];
    logic [9:0]  m_stk [$];
    bit          m_err;
    logic [15:0] m_cnt;
    bit          e_abs;
    logic [9:0]  e_tgt;

    // Apply one cycle of inputs (at negedge) and derive expected outputs.
    task automatic drive(input bit rst, input bit br, input bit cf, input bit call,
                         input bit ret, input logic [4:0] idx, input bit we,
                         input logic [4:0] widx, input logic [9:0] wdat,
                         input logic [9:0] pc);
        reset = rst; br_en = br; cond_flag = cf; call_en = call; ret_en = ret;
        lut_idx = idx; lut_wr_en = we; lut_wr_idx = widx; lut_wr_data = wdat;
        prog_ctr = pc;
        e_abs = 0; e_tgt = '0;
        if (!rst) begin
            if (ret) begin
                if (m_stk.size() > 0) begin e_abs = 1; e_tgt = m_stk[$]; end
            end else if (call) begin
                if (m_stk.size() < 8) begin e_abs = 1; e_tgt = m_lut[idx]; end
            end else if (br && cf) begin
                e_abs = 1; e_tgt = m_lut[idx];
            end
        end
        #1;
    endtask

    // Clock edge; commit the reference model using the pre-edge inputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_lut[i] = '0;
            m_stk.delete();
            m_err = 0;
            m_cnt = '0;
        end else begin
            if (ret_en) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_err = 1;
            end else if (call_en) begin
                if (m_stk.size() < 8) m_stk.push_back(10'((prog_ctr + 1) % 1024));
                else m_err = 1;
            end
            if (lut_wr_en) m_lut[lut_wr_idx] = lut_wr_data;
            if (e_abs) m_cnt = m_cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0);
    endtask

    task automatic write_lut(input logic [4:0] idx, input logic [9:0] val);
        drive(0, 0, 0, 0, 0, 5'd0, 1, idx, val, 10'd0);
        tick();
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 1, 5'd3, 1, 5'd3, 10'h155, 10'h0AA);
        checks++;
        if ({absjump_en, target} !== 11'd0) begin
            failures++;
            $display("FAIL reset_jump: got abs=%0b tgt=%h want 0/000", absjump_en, target);
        end
        tick();
        checks++;
        if ({stack_full, stack_empty, stack_err} !== 3'b010) begin
            failures++;
            $display("FAIL reset_flags: got f/e/err=%b want 010", {stack_full, stack_empty, stack_err});
        end
        // Every table entry must read back as zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 1, 0, 0, 5'(i), 0, 5'd0, 10'd0, 10'd0);
            checks++;
            if ({absjump_en, target} !== {1'b1, 10'd0}) begin
                failures++;
                $display("FAIL reset_lut[%0d]: got abs=%0b tgt=%h want 1/000", i, absjump_en, target);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        write_lut(5'd3, 10'h120);
        drive(0, 1, 1, 0, 0, 5'd3, 0, 5'd0, 10'd0, 10'd0);
        checks++;
        if ({absjump_en, target} !== {1'b1, 10'h120}) begin
            failures++;
            $display("FAIL br_taken: got abs=%0b tgt=%h want 1/120", absjump_en, target);
        end
        tick();
        drive(0, 1, 0, 0, 0, 5'd3, 0, 5'd0, 10'd0, 10'd0);
        checks++;
        if ({absjump_en, target} !== 11'd0) begin
            failures++;
            $display("FAIL br_not_taken: got abs=%0b tgt=%h want 0/000", absjump_en, target);
        end
        tick();
    endtask

    task automatic test_call_ret();
        write_lut(5'd1, 10'h200);
        drive(0, 0, 0, 1, 0, 5'd1, 0, 5'd0, 10'd0, 10'h050);
        checks++;
        if ({absjump_en, target} !== {1'b1, 10'h200}) begin
            failures++;
            $display("FAIL call: got abs=%0b tgt=%h want 1/200", absjump_en, target);
        end
        tick();
        checks++;
        if (stack_empty !== 1'b0) begin
            failures++;
            $display("FAIL call_empty: got %0b want 0", stack_empty);
        end
        drive(0, 0, 0, 0, 1, 5'd0, 0, 5'd0, 10'd0, 10'd0);
        checks++;
        if ({absjump_en, target} !== {1'b1, 10'h051}) begin
            failures++;
            $display("FAIL ret: got abs=%0b tgt=%h want 1/051", absjump_en, target);
        end
        tick();
        checks++;
        if (stack_empty !== 1'b1) begin
            failures++;
            $display("FAIL ret_empty: got %0b want 1", stack_empty);
        end
    endtask

    task automatic test_nested();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 0, 5'd1, 0, 5'd0, 10'd0, 10'(16 + i));
            tick();
        end
        checks++;
        if ({stack_full, stack_err} !== 2'b10) begin
            failures++;
            $display("FAIL nest_full: got full/err=%b want 10", {stack_full, stack_err});
        end
        drive(0, 0, 0, 1, 0, 5'd1, 0, 5'd0, 10'd0, 10'h018);
        checks++;
        if ({absjump_en, target} !== 11'd0) begin
            failures++;
            $display("FAIL overflow_jump: got abs=%0b tgt=%h want 0/000", absjump_en, target);
        end
        tick();
        checks++;
        if ({stack_full, stack_err} !== 2'b11) begin
            failures++;
            $display("FAIL overflow_flags: got full/err=%b want 11", {stack_full, stack_err});
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1, 5'd0, 0, 5'd0, 10'd0, 10'd0);
            checks++;
            if ({absjump_en, target} !== {1'b1, 10'(24 - i)} || e_tgt !== 10'(24 - i)) begin
                failures++;
                $display("FAIL nest_ret%0d: got abs=%0b tgt=%h want 1/%h", i, absjump_en, target, 10'(24 - i));
            end
            tick();
        end
        checks++;
        if ({stack_empty, stack_err} !== 2'b11) begin
            failures++;
            $display("FAIL nest_end: got empty/err=%b want 11", {stack_empty, stack_err});
        end
    endtask

    task automatic test_underflow();
        drive(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0);
        tick();
        drive(0, 0, 0, 0, 1, 5'd0, 0, 5'd0, 10'd0, 10'd0);
        checks++;
        if ({absjump_en, target} !== 11'd0) begin
            failures++;
            $display("FAIL underflow_jump: got abs=%0b tgt=%h want 0/000", absjump_en, target);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            idle();
            tick();
        end
        checks++;
        if (stack_err !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky: got err=%0b want 1", stack_err);
        end
        drive(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0);
        tick();
        checks++;
        if (stack_err !== 1'b0) begin
            failures++;
            $display("FAIL err_reset: got err=%0b want 0", stack_err);
        end
    endtask

    task automatic test_priority();
        write_lut(5'd2, 10'h111);
        drive(0, 0, 0, 1, 0, 5'd2, 0, 5'd0, 10'd0, 10'h0AA);
        tick();
        drive(0, 1, 1, 1, 1, 5'd2, 0, 5'd0, 10'd0, 10'h123);
        checks++;
        if ({absjump_en, target} !== {1'b1, 10'h0AB}) begin
            failures++;
            $display("FAIL priority_jump: got abs=%0b tgt=%h want 1/0AB", absjump_en, target);
        end
        tick();
        checks++;
        if ({stack_empty, stack_err} !== 2'b10) begin
            failures++;
            $display("FAIL priority_flags: got empty/err=%b want 10", {stack_empty, stack_err});
        end
    endtask

    task automatic test_war();
        write_lut(5'd5, 10'h0C3);
        drive(0, 1, 1, 0, 0, 5'd5, 1, 5'd5, 10'h3FF, 10'd0);
        checks++;
        if ({absjump_en, target} !== {1'b1, 10'h0C3}) begin
            failures++;
            $display("FAIL war_old: got abs=%0b tgt=%h want 1/0C3", absjump_en, target);
        end
        tick();
        drive(0, 1, 1, 0, 0, 5'd5, 0, 5'd0, 10'd0, 10'd0);
        checks++;
        if ({absjump_en, target} !== {1'b1, 10'h3FF}) begin
            failures++;
            $display("FAIL war_new: got abs=%0b tgt=%h want 1/3FF", absjump_en, target);
        end
        tick();
        drive(0, 0, 0, 1, 0, 5'd5, 0, 5'd0, 10'd0, 10'h3FF);
        tick();
        drive(0, 0, 0, 0, 1, 5'd0, 0, 5'd0, 10'd0, 10'd0);
        checks++;
        if ({absjump_en, target} !== {1'b1, 10'h000}) begin
            failures++;
            $display("FAIL pc_wrap: got abs=%0b tgt=%h want 1/000", absjump_en, target);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        write_lut(5'd7, 10'h2A5);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 5'd7, 0, 5'd0, 10'd0, 10'(100 + i));
            tick();
        end
        drive(1, 0, 0, 1, 0, 5'd7, 0, 5'd0, 10'd0, 10'd0);
        tick();
        drive(0, 1, 1, 0, 1, 5'd7, 0, 5'd0, 10'd0, 10'd0);
        checks++;
        if ({absjump_en, target} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_ret: got abs=%0b tgt=%h want 0/000", absjump_en, target);
        end
        tick();
        drive(0, 1, 1, 0, 0, 5'd7, 0, 5'd0, 10'd0, 10'd0);
        checks++;
        if ({absjump_en, target} !== {1'b1, 10'h000}) begin
            failures++;
            $display("FAIL reset_mid_lut: got abs=%0b tgt=%h want 1/000", absjump_en, target);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 31)), $urandom_range(0, 1),
                  5'($urandom_range(0, 31)), 10'($urandom), 10'($urandom));
            checks++;
            if ({absjump_en, target} !== {e_abs, e_tgt}) begin
                failures++;
                $display("FAIL rand_jump[%0d]: got abs=%0b tgt=%h want %0b/%h", n, absjump_en, target, e_abs, e_tgt);
            end
            tick();
            checks++;
            if ({stack_full, stack_empty, stack_err} !==
                {(m_stk.size() == 8), (m_stk.size() == 0), m_err}) begin
                failures++;
                $display("FAIL rand_flags[%0d]: got f/e/err=%b want %b", n,
                         {stack_full, stack_empty, stack_err},
                         {(m_stk.size() == 8), (m_stk.size() == 0), m_err});
            end
`ifdef BRANCH_CTRL_TAKEN_CNT_EN
            checks++;
            if (taken_cnt !== m_cnt) begin
                failures++;
                $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, taken_cnt, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_lut[i] = '0;
        m_err = 0;
        m_cnt = '0;
        @(negedge clk);
        test_reset();
        test_branch();
        test_call_ret();
        test_nested();
        test_underflow();
        test_priority();
        test_war();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
